// File: rtl/status_event_sched.sv
// status_event_sched: collects edge/level events, coalesces them over a holdoff window
// and presents one held snapshot with an interrupt until firmware acknowledges the read.
module status_event_sched #(
   parameter int         NumInputs     = 8,
   parameter logic [7:0] ModeMask      = 8'h00,
   parameter logic [7:0] MaskValue     = 8'h7F,
   parameter int         HoldoffCycles = 0
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] events,
   input  logic       rd_strobe,
   output logic [7:0] status_out,
   output logic       intr,
   output logic       overflow,
   output logic       busy
);
   localparam logic [7:0] Act    = 8'((9'd1 << NumInputs) - 9'd1);
   localparam logic [7:0] Eff    = MaskValue & Act;
   localparam logic [7:0] HStart = 8'(HoldoffCycles - 1);
   typedef enum logic [1:0] {IDLE, HOLDOFF, PRESENT, CLEAR} state_t;
   state_t     state, state_nx;
   logic [7:0] ev_q, ev_q2, pend, cap, cnt, cnt_nx;
   logic       xfer, accept;
   assign cap  = ((ev_q & ~ev_q2 & ModeMask) | (ev_q & ~ModeMask)) & Act;
   assign busy = state != IDLE;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      xfer     = 1'b0;
      accept   = 1'b0;
      case (state)
         IDLE:
            if (|(pend & Eff)) begin
               if (HoldoffCycles == 0) begin
                  xfer     = 1'b1;
                  state_nx = PRESENT;
               end else begin
                  cnt_nx   = HStart;
                  state_nx = HOLDOFF;
               end
            end
         HOLDOFF:
            if (cnt == 8'd0) begin
               xfer     = 1'b1;
               state_nx = PRESENT;
            end else cnt_nx = cnt - 8'd1;
         PRESENT:
            if (rd_strobe) begin
               accept   = 1'b1;
               state_nx = CLEAR;
            end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         ev_q       <= '0;
         ev_q2      <= '0;
         pend       <= '0;
         cnt        <= '0;
         status_out <= '0;
         intr       <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         ev_q     <= events & Act;
         ev_q2    <= ev_q;
         // a capture in the transfer cycle seeds the fresh pending set
         pend     <= xfer ? cap : (pend | cap);
         overflow <= (|(cap & ModeMask & pend)) | (overflow & ~accept);
         if (xfer) begin
            status_out <= pend;
            intr       <= 1'b1;
         end else if (accept) begin
            status_out <= '0;
            intr       <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_status_event_sched.sv
// tb_status_event_sched: directed scoreboard bench over four parameter variants.
module tb_status_event_sched;
   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] ev [4];
   logic       rd [4];
   logic [7:0] st [4];
   logic       irq [4];
   logic       ov [4];
   logic       bz [4];
   logic [7:0] exp_q [$];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   status_event_sched #(.NumInputs(8), .ModeMask(8'hFF), .MaskValue(8'h7F), .HoldoffCycles(0)) u0 (
      .clock(clk), .reset_n(reset_n), .events(ev[0]), .rd_strobe(rd[0]),
      .status_out(st[0]), .intr(irq[0]), .overflow(ov[0]), .busy(bz[0]));
   status_event_sched #(.NumInputs(8), .ModeMask(8'hFF), .MaskValue(8'h7F), .HoldoffCycles(16)) u1 (
      .clock(clk), .reset_n(reset_n), .events(ev[1]), .rd_strobe(rd[1]),
      .status_out(st[1]), .intr(irq[1]), .overflow(ov[1]), .busy(bz[1]));
   status_event_sched #(.NumInputs(8), .ModeMask(8'h00), .MaskValue(8'h7F), .HoldoffCycles(16)) u2 (
      .clock(clk), .reset_n(reset_n), .events(ev[2]), .rd_strobe(rd[2]),
      .status_out(st[2]), .intr(irq[2]), .overflow(ov[2]), .busy(bz[2]));
   status_event_sched #(.NumInputs(4), .ModeMask(8'hFF), .MaskValue(8'h7F), .HoldoffCycles(0)) u3 (
      .clock(clk), .reset_n(reset_n), .events(ev[3]), .rd_strobe(rd[3]),
      .status_out(st[3]), .intr(irq[3]), .overflow(ov[3]), .busy(bz[3]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // waits for intr, checks edge count since stimulus and pops the expected snapshot
   task automatic expect_present(input int d, input int lat, input int n0, input string tag);
      int         n = n0;
      logic [7:0] e = 8'hxx;
      while (irq[d] !== 1'b1 && n < n0 + 300) begin
         tick();
         n++;
      end
      chk({tag, "_lat"}, n, lat);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      chk({tag, "_status"}, st[d], e);
      chk({tag, "_busy"}, bz[d], 1);
   endtask

   task automatic read_clear(input int d, input string tag);
      rd[d] = 1'b1;
      tick();
      rd[d] = 1'b0;
      chk({tag, "_clr_intr"}, irq[d], 0);
      chk({tag, "_clr_status"}, st[d], 0);
      chk({tag, "_clr_busy"}, bz[d], 1);
      tick();
      chk({tag, "_idle_busy"}, bz[d], 0);
   endtask

   task automatic double_pulse(input int d);
      ev[d] = 8'h01;
      tick();
      ev[d] = 8'h00;
      tick();
      tick();
      ev[d] = 8'h01;
      rd[d] = 1'b1;
      tick();
      ev[d] = 8'h00;
      rd[d] = 1'b0;
   endtask

   initial begin
      int hits;
      for (int i = 0; i < 4; i++) begin
         ev[i] = 8'h00;
         rd[i] = 1'b0;
      end
      reset_n = 1'b0;
      tick();
      chk("rst_intr", irq[0], 0);
      chk("rst_status", st[0], 0);
      chk("rst_busy", bz[0], 0);
      chk("rst_ovf", ov[0], 0);
      tick();
      reset_n = 1'b1;
      tick();

      // one-clock pulse, then a new event arriving while presenting
      ev[0] = 8'h01;
      exp_q.push_back(8'h01);
      tick();
      ev[0] = 8'h00;
      expect_present(0, 3, 1, "pulse");
      ev[0] = 8'h08;
      tick();
      ev[0] = 8'h00;
      tick();
      chk("held_status", st[0], 8'h01);
      chk("held_intr", irq[0], 1);
      exp_q.push_back(8'h08);
      read_clear(0, "pulse");
      expect_present(0, 2, 1, "repres");
      read_clear(0, "repres");

      // unmasked bit alone never interrupts, then rides along
      ev[0] = 8'h80;
      tick();
      ev[0] = 8'h00;
      hits = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (irq[0] !== 1'b0) hits++;
      end
      chk("unmasked_quiet", hits, 0);
      ev[0] = 8'h01;
      exp_q.push_back(8'h81);
      tick();
      ev[0] = 8'h00;
      expect_present(0, 3, 1, "ride");
      chk("ride_ovf", ov[0], 0);
      read_clear(0, "ride");

      // holdoff coalescing of two edges five clocks apart
      ev[1] = 8'h02;
      for (int i = 0; i < 5; i++) tick();
      ev[1] = 8'h06;
      exp_q.push_back(8'h06);
      expect_present(1, 19, 5, "coalesce");
      ev[1] = 8'h00;
      read_clear(1, "coalesce");

      // repeated edge inside the window flags overflow; rd during holdoff ignored
      exp_q.push_back(8'h01);
      double_pulse(1);
      expect_present(1, 19, 4, "ovf_edge");
      chk("ovf_set", ov[1], 1);
      read_clear(1, "ovf_edge");
      chk("ovf_cleared", ov[1], 0);

      exp_q.push_back(8'h01);
      double_pulse(2);
      expect_present(2, 19, 4, "ovf_level");
      chk("ovf_level_zero", ov[2], 0);
      read_clear(2, "ovf_level");

      // inputs above NumInputs are inert
      hits = 0;
      for (int i = 0; i < 40; i++) begin
         ev[3] = (i % 2 == 0) ? 8'h20 : 8'h00;
         tick();
         if (irq[3] !== 1'b0 || st[3][7:4] !== 4'h0) hits++;
      end
      chk("narrow_quiet", hits, 0);
      ev[3] = 8'h22;
      exp_q.push_back(8'h02);
      tick();
      ev[3] = 8'h00;
      expect_present(3, 3, 1, "narrow");
      read_clear(3, "narrow");

      // asynchronous reset while presenting
      ev[0] = 8'h01;
      exp_q.push_back(8'h01);
      tick();
      ev[0] = 8'h00;
      expect_present(0, 3, 1, "prerst");
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_intr", irq[0], 0);
      chk("arst_status", st[0], 0);
      chk("arst_busy", bz[0], 0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("arst_discard", irq[0], 0);
      chk("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
